// File: rtl/rs_integer_queue.sv
// Integer reservation station: collapsing age-ordered queue fed by Dispatch,
// woken by the integer CDB, and issuing the oldest ready entry to the ALU.
module rs_integer_queue #(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               rs_dest,
  input  logic [TAG_W+69:0]  rs_data,
  output logic               rs_is_full,
  input  logic               cdb_valid,
  input  logic [TAG_W+31:0]  cdb_data,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [TAG_W-1:0]   issue_rob_dest,
  output logic [3:0]         issue_op,
  output logic [31:0]        issue_a,
  output logic [31:0]        issue_b
);

  localparam int CW = $clog2(ENTRIES + 1);
  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [CW-1:0]      count_q, count_d, count_mid;
  logic [TAG_W-1:0]   dest_q [ENTRIES];
  logic [TAG_W-1:0]   dest_d [ENTRIES];
  logic [3:0]         op_q   [ENTRIES];
  logic [3:0]         op_d   [ENTRIES];
  logic [31:0]        val1_q [ENTRIES];
  logic [31:0]        val1_d [ENTRIES];
  logic [31:0]        val2_q [ENTRIES];
  logic [31:0]        val2_d [ENTRIES];
  logic [31:0]        w_val1 [ENTRIES];
  logic [31:0]        w_val2 [ENTRIES];
  logic [ENTRIES-1:0] rdy1_q, rdy1_d, rdy2_q, rdy2_d, w_rdy1, w_rdy2;
  logic               lock_q, lock_d;
  logic [IW-1:0]      lock_idx_q, lock_idx_d;

  logic               sel_found, fire, accept;
  logic [IW-1:0]      sel_idx;
  logic [TAG_W-1:0]   cdb_tag;
  logic               in_rdy1, in_rdy2;
  logic [31:0]        in_val1, in_val2;
  int unsigned        src;

  assign cdb_tag    = cdb_data[TAG_W+31:32];
  assign rs_is_full = (count_q == CW'(ENTRIES));

  // A stalled selection is pinned so a late wakeup of an older slot cannot
  // change the presented issue while the ALU holds off.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    if (lock_q) begin
      sel_found = 1'b1;
      sel_idx   = lock_idx_q;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (!sel_found && i < 32'(count_q) && rdy1_q[i] && rdy2_q[i]) begin
          sel_found = 1'b1;
          sel_idx   = IW'(i);
        end
      end
    end
  end

  always_comb begin
    issue_valid    = sel_found;
    issue_rob_dest = '0;
    issue_op       = '0;
    issue_a        = '0;
    issue_b        = '0;
    if (sel_found) begin
      issue_rob_dest = dest_q[sel_idx];
      issue_op       = op_q[sel_idx];
      issue_a        = val1_q[sel_idx];
      issue_b        = val2_q[sel_idx];
    end
  end

  always_comb begin
    w_rdy1 = '0;
    w_rdy2 = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      w_rdy1[i] = rdy1_q[i] || (cdb_valid && val1_q[i][TAG_W-1:0] == cdb_tag);
      w_rdy2[i] = rdy2_q[i] || (cdb_valid && val2_q[i][TAG_W-1:0] == cdb_tag);
      w_val1[i] = rdy1_q[i] ? val1_q[i] : (w_rdy1[i] ? cdb_data[31:0] : val1_q[i]);
      w_val2[i] = rdy2_q[i] ? val2_q[i] : (w_rdy2[i] ? cdb_data[31:0] : val2_q[i]);
    end
    in_rdy1 = rs_data[65] || (cdb_valid && rs_data[33+:TAG_W] == cdb_tag);
    in_rdy2 = rs_data[32] || (cdb_valid && rs_data[0+:TAG_W] == cdb_tag);
    in_val1 = (!rs_data[65] && in_rdy1) ? cdb_data[31:0] : rs_data[64:33];
    in_val2 = (!rs_data[32] && in_rdy2) ? cdb_data[31:0] : rs_data[31:0];
  end

  always_comb begin
    fire      = sel_found && issue_ready;
    accept    = rs_dest && !rs_is_full;
    src       = 0;
    rdy1_d    = '0;
    rdy2_d    = '0;
    // Shift-down and wakeup compose: each slot takes its upper neighbour's woken state.
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      src = (fire && i >= 32'(sel_idx) && i + 1 < ENTRIES) ? i + 1 : i;
      dest_d[i] = dest_q[src];
      op_d[i]   = op_q[src];
      rdy1_d[i] = w_rdy1[src];
      val1_d[i] = w_val1[src];
      rdy2_d[i] = w_rdy2[src];
      val2_d[i] = w_val2[src];
    end
    count_mid = count_q - CW'(fire);
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (accept && i == 32'(count_mid)) begin
        dest_d[i] = rs_data[TAG_W+69:70];
        op_d[i]   = rs_data[69:66];
        rdy1_d[i] = in_rdy1;
        val1_d[i] = in_val1;
        rdy2_d[i] = in_rdy2;
        val2_d[i] = in_val2;
      end
    end
    count_d    = count_mid + CW'(accept);
    lock_d     = sel_found && !issue_ready;
    lock_idx_d = sel_idx;
    if (flush) begin
      count_d = '0;
      lock_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      count_q    <= count_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    dest_q <= dest_d;
    op_q   <= op_d;
    rdy1_q <= rdy1_d;
    val1_q <= val1_d;
    rdy2_q <= rdy2_d;
    val2_q <= val2_d;
  end

endmodule

// File: tb/tb_rs_integer_queue.sv
// Randomized and directed bench for rs_integer_queue against a queue-based model.
module tb_rs_integer_queue;

  localparam int E = 4;

  logic        clk = 1'b0;
  logic        reset, flush, rs_dest, cdb_valid, issue_ready;
  logic [75:0] rs_data;
  logic [37:0] cdb_data;
  logic        rs_is_full, issue_valid;
  logic [5:0]  issue_rob_dest;
  logic [3:0]  issue_op;
  logic [31:0] issue_a, issue_b;

  rs_integer_queue #(.ENTRIES(E), .TAG_W(6)) dut (
    .clk(clk), .reset(reset), .flush(flush), .rs_dest(rs_dest), .rs_data(rs_data),
    .rs_is_full(rs_is_full), .cdb_valid(cdb_valid), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rob_dest(issue_rob_dest), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  dest;
    logic [3:0]  op;
    logic        r1;
    logic [31:0] v1;
    logic        r2;
    logic [31:0] v2;
    int unsigned id;
  } ent_t;

  ent_t        mq[$];
  logic        held = 1'b0;
  int unsigned held_id = 0;
  int unsigned next_id = 1;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [75:0] mk(input logic [5:0] d, input logic [3:0] op,
                                     input logic r1, input logic [31:0] v1,
                                     input logic r2, input logic [31:0] v2);
    return {d, op, r1, v1, r2, v2};
  endfunction

  function automatic ent_t wake(input ent_t e, input logic cv, input logic [37:0] cd);
    ent_t w = e;
    if (cv && !w.r1 && w.v1[5:0] == cd[37:32]) begin w.r1 = 1'b1; w.v1 = cd[31:0]; end
    if (cv && !w.r2 && w.v2[5:0] == cd[37:32]) begin w.r2 = 1'b1; w.v2 = cd[31:0]; end
    return w;
  endfunction

  // Oldest ready entry, unless an entry is already presented and waiting on the ALU.
  function automatic int msel();
    if (held)
      foreach (mq[i]) if (mq[i].id == held_id) return i;
    foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  task automatic cyc(input logic rst, input logic fl, input logic d, input logic [75:0] data,
                     input logic cv, input logic [37:0] cd, input logic ir);
    int   s;
    logic full;
    ent_t e;
    reset = rst; flush = fl; rs_dest = d; rs_data = data;
    cdb_valid = cv; cdb_data = cd; issue_ready = ir;
    if (!rst || fl) begin
      mq.delete();
      held = 1'b0;
    end else begin
      s    = msel();
      full = (mq.size() == E);
      e.id = (s >= 0) ? mq[s].id : 0;
      foreach (mq[i]) mq[i] = wake(mq[i], cv, cd);
      if (s >= 0 && ir) mq.delete(s);
      held    = (s >= 0) && !ir;
      held_id = e.id;
      if (d && !full) begin
        e = '{dest: data[75:70], op: data[69:66], r1: data[65], v1: data[64:33],
              r2: data[32], v2: data[31:0], id: next_id};
        next_id++;
        mq.push_back(wake(e, cv, cd));
      end
    end
    @(posedge clk);
    #1;
    s = msel();
    check("full", rs_is_full, (mq.size() == E));
    check("valid", issue_valid, (s >= 0));
    check("dest", issue_rob_dest, (s >= 0) ? mq[s].dest : 6'd0);
    check("op", issue_op, (s >= 0) ? mq[s].op : 4'd0);
    check("a", issue_a, (s >= 0) ? mq[s].v1 : 32'd0);
    check("b", issue_b, (s >= 0) ? mq[s].v2 : 32'd0);
  endtask

  task automatic idle(input logic ir);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, ir);
  endtask

  task automatic disp(input logic [75:0] data, input logic ir);
    cyc(1'b1, 1'b0, 1'b1, data, 1'b0, '0, ir);
  endtask

  initial begin
    logic [75:0] pkt;
    logic [37:0] cd;
    // reset with a concurrent dispatch strobe
    cyc(1'b0, 1'b0, 1'b1, mk(6'd9, 4'd1, 1'b1, 32'h1, 1'b1, 32'h2), 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, mk(6'd9, 4'd1, 1'b1, 32'h1, 1'b1, 32'h2), 1'b0, '0, 1'b1);
    check("rst_full", rs_is_full, 0);
    check("rst_valid", issue_valid, 0);
    check("rst_a", issue_a, 0);
    idle(1'b1);
    check("rst_empty", issue_valid, 0);

    disp(mk(6'd3, 4'd2, 1'b1, 32'h10, 1'b1, 32'h20), 1'b1);
    check("rd_valid", issue_valid, 1);
    check("rd_dest", issue_rob_dest, 3);
    check("rd_a", issue_a, 32'h10);
    check("rd_b", issue_b, 32'h20);
    idle(1'b1);
    check("rd_gone", issue_valid, 0);

    disp(mk(6'd4, 4'd1, 1'b0, 32'd5, 1'b1, 32'd7), 1'b1);
    check("wk_wait", issue_valid, 0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, {6'd5, 32'hDEADBEEF}, 1'b1);
    check("wk_valid", issue_valid, 1);
    check("wk_a", issue_a, 32'hDEADBEEF);
    idle(1'b1);
    cyc(1'b1, 1'b0, 1'b1, mk(6'd6, 4'd1, 1'b0, 32'd9, 1'b1, 32'd1), 1'b1, {6'd9, 32'h1234}, 1'b1);
    check("same_edge_valid", issue_valid, 1);
    check("same_edge_a", issue_a, 32'h1234);
    idle(1'b1);

    for (int k = 1; k <= 4; k++) disp(mk(6'(k), 4'd0, 1'b1, 32'(k), 1'b1, 32'(k)), 1'b0);
    check("fill_full", rs_is_full, 1);
    check("fill_head", issue_rob_dest, 1);
    disp(mk(6'd5, 4'd0, 1'b1, 32'd5, 1'b1, 32'd5), 1'b0);
    check("drop_head", issue_rob_dest, 1);
    for (int k = 2; k <= 4; k++) begin
      idle(1'b1);
      check("age_order", issue_rob_dest, 32'(k));
    end
    idle(1'b1);
    check("age_drained", issue_valid, 0);

    disp(mk(6'd7, 4'd0, 1'b0, 32'd9, 1'b1, 32'd0), 1'b0);
    disp(mk(6'd8, 4'd0, 1'b1, 32'd1, 1'b1, 32'd2), 1'b0);
    check("ooo_first", issue_rob_dest, 8);
    idle(1'b1);
    check("ooo_wait", issue_valid, 0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, {6'd9, 32'h77}, 1'b0);
    check("ooo_second", issue_rob_dest, 7);
    idle(1'b1);

    for (int k = 0; k < 3; k++) disp(mk(6'(k + 10), 4'd3, 1'b1, 32'd1, 1'b1, 32'd1), 1'b0);
    cyc(1'b1, 1'b1, 1'b1, mk(6'd20, 4'd0, 1'b1, 32'd0, 1'b1, 32'd0), 1'b0, '0, 1'b1);
    check("flush_full", rs_is_full, 0);
    check("flush_valid", issue_valid, 0);
    idle(1'b1);
    check("flush_empty", issue_valid, 0);

    for (int n = 0; n < 2000; n++) begin
      pkt = mk(6'($urandom_range(0, 63)), 4'($urandom), 1'($urandom_range(0, 2) == 0),
               {$urandom, 3'b000, 3'($urandom)}, 1'($urandom_range(0, 2) == 0),
               {$urandom, 3'b000, 3'($urandom)});
      cd  = {3'b000, 3'($urandom), 32'($urandom)};
      cyc(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 49) == 0),
          1'($urandom), pkt, 1'($urandom), cd, 1'($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs_integer_queue.md
Name: rs_integer_queue

Overview:
- Integer reservation station: receives the `rs_integer` packet from Dispatch and issues ready instructions to the integer ALU in age order.
- Snoops the integer CDB to wake up waiting operands.
- Drives `rs_is_full` back to Dispatch.
- Sits between Dispatch and the integer execution unit.

Parameters:
- ENTRIES, 4, number of station slots (2..16).
- TAG_W, 6, ROB tag width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- flush  input  1  misprediction flush; clears all entries
- rs_dest  input  1  dispatch write strobe
- rs_data  input  76  dispatch packet: [75:70] rob_dest, [69:66] alu_op, [65:33] src1, [32:0] src2
  - Each src field: bit32 = ready. Ready=1: [31:0] is the value. Ready=0: [5:0] is the producing ROB tag.
- rs_is_full  output  1  count == ENTRIES
- cdb_valid  input  1  CDB broadcast valid
- cdb_data  input  38  {tag[37:32], value[31:0]}
- issue_valid  output  1  an entry with both operands ready exists
- issue_ready  input  1  ALU accepts the issue this cycle
- issue_rob_dest  output  6  destination ROB tag of the issued entry
- issue_op  output  4  ALU op of the issued entry
- issue_a  output  32  operand 1 value
- issue_b  output  32  operand 2 value

Behaviour:
- Storage:
  - Collapsing queue of ENTRIES slots; slot 0 is the oldest.
  - Per slot: valid, rob_dest, op, rdy1, val1, rdy2, val2.
  - `count` = number of valid slots, kept contiguous from slot 0.
- Reset (`reset`==0 at posedge): all slot valid bits and count go to 0.
  - Outputs then: rs_is_full=0, issue_valid=0, issue_rob_dest=0, issue_op=0, issue_a=0, issue_b=0.
  - Reset mid-operation discards all entries; no issue occurs in the reset cycle.
- flush (`reset`=1, `flush`=1): same clearing as reset.
  - Dispatch, issue and wakeup in that cycle are ignored.
  - Reset has priority over flush.
- Issue select (combinational):
  - Lowest-index valid slot with rdy1 && rdy2.
  - issue_valid = 1 if such a slot exists.
  - issue_* outputs are that slot's fields; all issue_* data outputs are 0 when issue_valid=0.
  - Outputs must hold stable while issue_valid && !issue_ready, unless a flush or reset occurs.
- Issue handshake: when issue_valid && issue_ready at posedge, the selected slot is removed.
  - Higher slots shift down one index; count decrements.
- Dispatch:
  - Accepted at posedge iff rs_dest && !rs_is_full. The new entry is appended at index count, after any issue shift.
  - rs_dest while rs_is_full: dropped silently. Dispatch is responsible for stalling.
  - This holds even if an issue frees a slot in the same cycle, because rs_is_full is derived from registered count.
- Wakeup:
  - At posedge, for every valid slot and operand with rdy=0, tag == cdb_data[37:32] and cdb_valid: set rdy=1 and val = cdb_data[31:0].
  - Woken operands are issuable the next cycle (1-cycle wakeup latency).
- Simultaneous dispatch + CDB: if an incoming src has ready=0 and its tag matches a valid CDB tag, the entry is written with that operand ready and holding the CDB value. No lost wakeup.
- Simultaneous issue + wakeup + dispatch: all three apply in the same edge.
  - Shifted slots keep their wakeup results.
  - Count update: count + dispatch_accepted − issue_fired.
- Latency: a dispatch with both operands ready at edge N gives issue_valid=1 in cycle N+1.
- Width rules:
  - Tag compare uses 6 bits.
  - A not-ready operand's [31:6] is don't-care and is overwritten on wakeup.
  - count is clog2(ENTRIES+1) bits.
- rs_is_full is combinational from registered count only; it never depends on same-cycle inputs.

Test Plan:
- Reset: drive reset=0 for 2 cycles with rs_dest=1 → rs_is_full=0, issue_valid=0, all issue outputs 0; no entry is present after reset releases.
- Ready dispatch: dispatch rob_dest=3, op=2, src1={1,0x10}, src2={1,0x20}, with issue_ready=1 → next cycle issue_valid=1, issue_rob_dest=3, issue_a=0x10, issue_b=0x20; the cycle after, issue_valid=0.
- Wakeup:
  - Dispatch src1={0,tag 5}, then cdb_valid=1, cdb_data={5,0xDEADBEEF} → issue_valid becomes 1 one cycle after the CDB edge, with issue_a=0xDEADBEEF.
  - A same-edge dispatch+CDB with the same tag → issue_valid=1 the next cycle.
- Age order + backpressure:
  - Fill 4 entries with tags 1..4, all ready, issue_ready=0 → rs_is_full=1, issue_rob_dest=1 held stable.
  - A 5th dispatch is dropped.
  - Raise issue_ready → issued tags in order 1,2,3,4, then issue_valid=0.
- Out-of-order: entry A (tag 7) waiting on tag 9, entry B (tag 8) ready → tag 8 issues first; tag 7 issues after CDB tag 9.
- Flush with 3 entries and a concurrent dispatch+issue → next cycle count=0, rs_is_full=0, issue_valid=0.
